vec_dot_product_pipe_accum: RTL and testbench

Pipelined, parametrised successor to the combinational 8-lane dot-product blocks. It computes the dot product of N-element vectors of W-bit elements through a registered multiply stage and a registered adder tree. Signed or unsigned operation is selected by parameter. It accumulates across multiple input beats so long vectors can be streamed in chunks, and it uses valid/ready handshakes on both sides to sit between a vector source and a result consumer.

---
 rtl/dot_prod_pkg.sv | 26 ++
 rtl/vec_dot_product_tree_level.sv | 43 ++++
 rtl/vec_dot_product_pipe_accum.sv | 134 +++++++++++++
 tb/tb_vec_dot_product_pipe_accum.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_prod_pkg.sv
// Shared sizing helpers for the pipelined dot-product block and its adder-tree levels.
package dot_prod_pkg;

    function automatic int lvl_w(input int w, input int k);
        return 2 * w + k;
    endfunction

    function automatic int tree_leaves(input int n);
        return 1 << $clog2(n);
    endfunction

    // Bit offset of tree level k inside the flattened bus (level 0 = products).
    function automatic int lvl_off(input int w, input int n, input int k);
        int off;
        off = 0;
        for (int j = 0; j < k; j++) begin
            off += (tree_leaves(n) >> j) * lvl_w(w, j);
        end
        return off;
    endfunction

    function automatic logic ext_bit(input logic msb, input bit sgn);
        return msb & sgn;
    endfunction

endpackage

// File: rtl/vec_dot_product_tree_level.sv
// One registered pairwise-add level of the adder tree; each sum is one bit wider than its inputs.
module vec_dot_product_tree_level
    import dot_prod_pkg::*;
#(
    parameter int PAIRS  = 1,
    parameter int IN_W   = 16,
    parameter int SIGNED = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_valid,
    input  logic                      in_last,
    input  logic [2*PAIRS*IN_W-1:0]   in_data,
    output logic [PAIRS*(IN_W+1)-1:0] out_data,
    output logic                      out_valid,
    output logic                      out_last
);
    localparam bit SG = (SIGNED != 0);

    logic [PAIRS*(IN_W+1)-1:0] w_sum;

    for (genvar p = 0; p < PAIRS; p++) begin : g_pair
        logic [IN_W-1:0] w_a, w_b;
        assign w_a = in_data[(2*p)*IN_W +: IN_W];
        assign w_b = in_data[(2*p+1)*IN_W +: IN_W];
        assign w_sum[p*(IN_W+1) +: IN_W+1] = {ext_bit(w_a[IN_W-1], SG), w_a}
                                           + {ext_bit(w_b[IN_W-1], SG), w_b};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_last  <= in_last;
            out_data  <= w_sum;
        end
    end

endmodule

// File: rtl/vec_dot_product_pipe_accum.sv
// Pipelined N-lane dot product: product register, L registered tree levels, then a
// multi-beat accumulator with sticky overflow feeding a valid/ready result register.
module vec_dot_product_pipe_accum
    import dot_prod_pkg::*;
#(
    parameter int N      = 8,
    parameter int W      = 8,
    parameter int SIGNED = 0,
    parameter int ACC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   vec_a,
    input  logic [N*W-1:0]   vec_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] dot_product,
    output logic             out_overflow
);
    localparam int L       = $clog2(N);
    localparam int LEAVES  = tree_leaves(N);
    localparam int PW      = lvl_w(W, 0);
    localparam int TW      = lvl_w(W, L);
    localparam int BUS_W   = lvl_off(W, N, L + 1);
    localparam int SUM_OFF = lvl_off(W, N, L);
    localparam bit SG      = (SIGNED != 0);

    logic                  w_adv;
    logic [LEAVES*PW-1:0]  w_prod, r_prod;
    logic                  r_pvld, r_plast;
    logic [BUS_W-1:0]      w_tree;
    logic [L:0]            w_vld, w_last;
    logic [TW-1:0]         w_sum;
    logic [ACC_W-1:0]      w_ext;
    logic [ACC_W:0]        w_add;
    logic                  w_ovf;
    logic [ACC_W-1:0]      r_acc;
    logic                  r_ovf;

    // A held result freezes every stage, so nothing in flight can be overwritten.
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = ~rst & w_adv;

    for (genvar i = 0; i < LEAVES; i++) begin : g_mul
        if (i < N) begin : g_lane
            logic [W-1:0] w_a, w_b;
            assign w_a = vec_a[i*W +: W];
            assign w_b = vec_b[i*W +: W];
            assign w_prod[i*PW +: PW] = {{W{ext_bit(w_a[W-1], SG)}}, w_a}
                                      * {{W{ext_bit(w_b[W-1], SG)}}, w_b};
        end else begin : g_pad
            assign w_prod[i*PW +: PW] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pvld  <= 1'b0;
            r_plast <= 1'b0;
            r_prod  <= '0;
        end else if (w_adv) begin
            r_pvld  <= in_valid;
            r_plast <= in_valid & in_last;
            r_prod  <= w_prod;
        end
    end

    assign w_tree[0 +: LEAVES*PW] = r_prod;
    assign w_vld[0]               = r_pvld;
    assign w_last[0]              = r_plast;

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int IW    = lvl_w(W, k - 1);
        localparam int P     = LEAVES >> k;
        localparam int OFF_I = lvl_off(W, N, k - 1);
        localparam int OFF_O = lvl_off(W, N, k);
        vec_dot_product_tree_level #(
            .PAIRS (P),
            .IN_W  (IW),
            .SIGNED(SIGNED)
        ) u_lvl (
            .clk      (clk),
            .rst      (rst),
            .en       (w_adv),
            .in_valid (w_vld[k-1]),
            .in_last  (w_last[k-1]),
            .in_data  (w_tree[OFF_I +: 2*P*IW]),
            .out_data (w_tree[OFF_O +: P*(IW+1)]),
            .out_valid(w_vld[k]),
            .out_last (w_last[k])
        );
    end

    assign w_sum = w_tree[SUM_OFF +: TW];

    if (ACC_W > TW) begin : g_ext
        assign w_ext = {{(ACC_W-TW){ext_bit(w_sum[TW-1], SG)}}, w_sum};
    end else begin : g_noext
        assign w_ext = w_sum;
    end

    assign w_add = {1'b0, r_acc} + {1'b0, w_ext};
    assign w_ovf = SG ? ((r_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_add[ACC_W-1] != r_acc[ACC_W-1]))
                      : w_add[ACC_W];

    // With w_adv high a held result is always being consumed, so out_valid
    // simply follows whether a new last beat lands this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc        <= '0;
            r_ovf        <= 1'b0;
            out_valid    <= 1'b0;
            dot_product  <= '0;
            out_overflow <= 1'b0;
        end else if (w_adv) begin
            out_valid <= w_vld[L] & w_last[L];
            if (w_vld[L]) begin
                if (w_last[L]) begin
                    dot_product  <= w_add[ACC_W-1:0];
                    out_overflow <= r_ovf | w_ovf;
                    r_acc        <= '0;
                    r_ovf        <= 1'b0;
                end else begin
                    r_acc <= w_add[ACC_W-1:0];
                    r_ovf <= r_ovf | w_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_dot_product_pipe_accum.sv
// Bench: three variants (unsigned/32, signed/32, unsigned/20) share one stimulus stream and are
// scored against an arithmetic per-vector reference with wrap/overflow range rules.
module tb_vec_dot_product_pipe_accum;
    localparam int N = 8;
    localparam int W = 8;
    localparam logic [63:0] ONES = {8{8'h01}};
    localparam logic [63:0] TWOS = {8{8'h02}};
    localparam logic [63:0] THRS = {8{8'h03}};
    localparam logic [63:0] FFS  = {8{8'hFF}};
    localparam logic [63:0] M128 = {8{8'h80}};
    localparam logic [63:0] P127 = {8{8'h7F}};

    logic           clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [N*W-1:0] vec_a = '0, vec_b = '0;
    logic [2:0]     rdy, ov, of;
    logic [31:0]    dp0, dp1;
    logic [19:0]    dp2;
    wire            in_ready = rdy[0];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    vec_dot_product_pipe_accum #(.N(N), .W(W), .SIGNED(0), .ACC_W(32)) u_uns (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .vec_a(vec_a), .vec_b(vec_b),
        .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready), .dot_product(dp0), .out_overflow(of[0]));
    vec_dot_product_pipe_accum #(.N(N), .W(W), .SIGNED(1), .ACC_W(32)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .vec_a(vec_a), .vec_b(vec_b),
        .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready), .dot_product(dp1), .out_overflow(of[1]));
    vec_dot_product_pipe_accum #(.N(N), .W(W), .SIGNED(0), .ACC_W(20)) u_o20 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .vec_a(vec_a), .vec_b(vec_b),
        .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready), .dot_product(dp2), .out_overflow(of[2]));

    typedef struct { logic [63:0] v; bit o; } res_t;
    res_t        q[3][$];
    longint      racc[3];
    bit          rovf[3];
    bit          hv[3];
    logic [63:0] hval[3];
    int          n_chk = 0, n_err = 0;
    int          acc_cyc = 0;
    bit          rdone = 1'b0;

    function automatic int accw(input int d); return (d == 2) ? 20 : 32; endfunction
    function automatic bit sg(input int d); return d == 1; endfunction
    function automatic logic [63:0] got(input int d);
        case (d)
            0:       return {32'b0, dp0};
            1:       return {32'b0, dp1};
            default: return {44'b0, dp2};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] g, input logic [63:0] e);
        n_chk++;
        if (g !== e) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, g, e);
        end
    endtask

    // Reference: exact dot product per beat, added to a value held in the ACC_W range.
    task automatic model_beat();
        for (int d = 0; d < 3; d++) begin
            longint s, t, lim, u;
            bit o;
            res_t e;
            s = 0;
            for (int i = 0; i < N; i++) begin
                if (sg(d)) s += longint'($signed(vec_a[i*W +: W])) * longint'($signed(vec_b[i*W +: W]));
                else       s += longint'(vec_a[i*W +: W]) * longint'(vec_b[i*W +: W]);
            end
            lim = longint'(1) << accw(d);
            t   = racc[d] + s;
            o   = sg(d) ? (t < -(lim / 2) || t >= lim / 2) : (t < 0 || t >= lim);
            u   = t % lim;
            if (u < 0) u += lim;
            if (in_last) begin
                e.v = u;
                e.o = rovf[d] | o;
                q[d].push_back(e);
                racc[d] = 0;
                rovf[d] = 1'b0;
            end else begin
                racc[d] = (sg(d) && u >= lim / 2) ? u - lim : u;
                rovf[d] = rovf[d] | o;
            end
        end
    endtask

    task automatic mon();
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                q[d].delete();
                racc[d] = 0;
                rovf[d] = 1'b0;
                hv[d]   = 1'b0;
            end
        end else begin
            if (in_valid && in_ready) model_beat();
            for (int d = 0; d < 3; d++) begin
                if (hv[d]) begin
                    chk($sformatf("hold_vld%0d", d), ov[d], 1);
                    chk($sformatf("hold_val%0d", d), got(d), hval[d]);
                end
                hv[d]   = ov[d] && !out_ready;
                hval[d] = got(d);
                if (ov[d] && out_ready) begin
                    if (q[d].size() == 0) chk($sformatf("spurious%0d", d), ov[d], 0);
                    else begin
                        res_t e;
                        e = q[d].pop_front();
                        chk($sformatf("val%0d", d), got(d), e.v);
                        chk($sformatf("ovf%0d", d), of[d], e.o);
                    end
                end
            end
        end
    endtask

    always @(negedge clk) mon();

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input bit last);
        int n;
        n = 0;
        vec_a = a; vec_b = b; in_last = last; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) chk("rdy_timeout", in_ready, 1);
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_res(input int d, output logic [63:0] v, output logic o, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!ov[d] && n < 50) begin @(negedge clk); n++; end
        chk("res_seen", ov[d], 1);
        v   = got(d);
        o   = of[d];
        lat = cyc - acc_cyc;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] v, a, b;
        logic        o;
        int          lat, nb;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", in_ready, 0);
        chk("rst_vld", ov, 0);
        chk("rst_dp0", dp0, 0);
        chk("rst_dp2", dp2, 0);
        chk("rst_ovf", of, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        send(FFS, FFS, 1'b1);
        wait_res(0, v, o, lat);
        chk("max_val", v, 520200);
        chk("max_ovf", o, 0);
        chk("max_lat", lat, 4);
        idle(2);

        send(ONES, ONES, 1'b0);
        send(ONES, ONES, 1'b0);
        send(ONES, ONES, 1'b1);
        wait_res(0, v, o, lat);
        chk("multi_val", v, 24);
        idle(2);

        send(M128, P127, 1'b1);
        wait_res(1, v, o, lat);
        chk("sgn_val", v, 64'h0000_0000_FFFE_0400);
        chk("sgn_ovf", o, 0);
        idle(2);

        out_ready = 1'b0;
        fork
            begin
                send(ONES, ONES, 1'b1);
                send(TWOS, ONES, 1'b1);
                send(THRS, ONES, 1'b1);
            end
            begin
                idle(10);
                @(negedge clk);
                chk("bp_rdy", in_ready, 0);
                chk("bp_vld", ov[0], 1);
                chk("bp_first", dp0, 8);
                @(posedge clk); #1;
                out_ready = 1'b1;
                #1;
                chk("bp_rdy_comb", in_ready, 1);
            end
        join
        idle(10);

        send(FFS, FFS, 1'b0);
        send(FFS, FFS, 1'b0);
        send(FFS, FFS, 1'b1);
        wait_res(2, v, o, lat);
        chk("o20_val", v, 512024);
        chk("o20_ovf", o, 1);
        send(ONES, ONES, 1'b1);
        wait_res(2, v, o, lat);
        chk("o20_next_val", v, 8);
        chk("o20_next_ovf", o, 0);
        idle(3);

        send(FFS, FFS, 1'b0);
        send(FFS, FFS, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_vld", ov[0], 0);
        chk("post_rst_rdy", in_ready, 1);
        @(posedge clk); #1;
        send(ONES, ONES, 1'b1);
        wait_res(0, v, o, lat);
        chk("post_rst_val", v, 8);
        idle(3);

        rdone = 1'b0;
        fork
            begin
                for (int vi = 0; vi < 100; vi++) begin
                    nb = $urandom_range(1, 4);
                    for (int bi = 0; bi < nb; bi++) begin
                        a = ($urandom_range(0, 3) == 0) ? FFS : {$urandom, $urandom};
                        b = ($urandom_range(0, 3) == 0) ? FFS : {$urandom, $urandom};
                        send(a, b, bi == nb - 1);
                        idle($urandom_range(0, 2));
                    end
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        idle(30);
        for (int d = 0; d < 3; d++) chk($sformatf("drain%0d", d), q[d].size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
